// File: rtl/apb_txn_sequencer_if.sv
// apb_txn_sequencer_if
//   Bundles the three channels of the APB transaction sequencer:
//     cmd_*  : command push channel (valid/ready) into the command FIFO
//     m_p*   : APB requester bus towards the completer
//     rsp_*  : response channel (valid/ready) carrying completion records
//   Modports:
//     master : the sequencer side (accepts commands, drives APB, returns responses)
//     slave  : the user/completer side (pushes commands, answers APB, takes responses)
interface apb_txn_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  m_psel;
  logic                  m_penable;
  logic                  m_pwrite;
  logic [ADDR_WIDTH-1:0] m_paddr;
  logic [DATA_WIDTH-1:0] m_pwdata;
  logic [DATA_WIDTH-1:0] m_prdata;
  logic                  m_pready;
  logic                  m_pslverr;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [LAT_WIDTH-1:0]  rsp_latency;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    input  m_prdata, m_pready, m_pslverr,
    output rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout, rsp_latency,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    output m_prdata, m_pready, m_pslverr,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout, rsp_latency,
    output rsp_ready
  );
endinterface

// File: rtl/apb_txn_sequencer.sv
// apb_txn_sequencer
//   Queued APB requester. Commands are pushed into a FIFO and issued one at a
//   time as APB SETUP/ACCESS transfers; every completion (normal or timeout)
//   produces a response record with read data, error, timeout flag and the
//   latency measured from SETUP to completion. Running statistics are kept.
// Ports:
//   pclk, preset_n   : clock, asynchronous active-low reset
//   bus (master)     : cmd_* push channel, m_p* APB bus, rsp_* response channel
//   fifo_level       : commands queued, not counting the one in flight
//   busy             : transfer machine active or commands pending
//   stat_clear       : synchronous clear of the statistics
//   stat_*           : completion count, error count, timeout count,
//                      min/max latency of non-timeout transfers
module apb_txn_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int LAT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         pclk,
  input  logic                         preset_n,
  apb_txn_sequencer_if.master          bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         busy,
  input  logic                         stat_clear,
  output logic [LAT_WIDTH-1:0]         stat_count,
  output logic [LAT_WIDTH-1:0]         stat_errors,
  output logic [LAT_WIDTH-1:0]         stat_timeouts,
  output logic [LAT_WIDTH-1:0]         stat_lat_min,
  output logic [LAT_WIDTH-1:0]         stat_lat_max
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  // One extra value of headroom so TIMEOUT_CYCLES=1 still gets a 1-bit counter
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_WIDTH-1:0] LAT_ONES  = '1;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t               state;
  logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   head;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       level;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic [LAT_WIDTH-1:0] lat_cnt;
  logic [LAT_WIDTH-1:0] lat_inc;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 done;
  logic [LAT_WIDTH-1:0] cnt_nxt, err_nxt, tmo_nxt, min_nxt, max_nxt;

  function automatic logic [LAT_WIDTH-1:0] sat_inc(input logic [LAT_WIDTH-1:0] v);
    return (v == LAT_ONES) ? v : v + LAT_WIDTH'(1);
  endfunction

  assign fifo_empty    = (level == '0);
  assign fifo_full     = (level == (PTR_W+1)'(FIFO_DEPTH));
  assign bus.cmd_ready = !fifo_full;
  assign push          = bus.cmd_valid && !fifo_full;
  // A new command is taken from IDLE, or straight from RESP once the response is accepted
  assign pop           = !fifo_empty && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
  assign head          = fifo_mem[rd_ptr];
  assign fifo_level    = level;
  assign busy          = (state != IDLE) || !fifo_empty;
  assign lat_inc       = sat_inc(lat_cnt);
  assign done          = (state == ACCESS) && (bus.m_pready || (wait_cnt == WAIT_LAST));

  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Transfer machine; issuing a popped command overrides the per-state
  // next-state so RESP can chain directly into SETUP.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state           <= IDLE;
      bus.m_psel      <= 1'b0;
      bus.m_penable   <= 1'b0;
      bus.m_pwrite    <= 1'b0;
      bus.m_paddr     <= '0;
      bus.m_pwdata    <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_write   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.rsp_latency <= '0;
      lat_cnt         <= '0;
      wait_cnt        <= '0;
    end else begin
      case (state)
        IDLE: ;
        SETUP: begin
          bus.m_penable <= 1'b1;
          lat_cnt       <= lat_inc;
          state         <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            // pready takes priority over an expiring timeout
            bus.m_psel      <= 1'b0;
            bus.m_penable   <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_write   <= bus.m_pwrite;
            bus.rsp_latency <= lat_cnt;
            bus.rsp_timeout <= !bus.m_pready;
            bus.rsp_err     <= bus.m_pready && bus.m_pslverr;
            bus.rsp_rdata   <= (bus.m_pready && !bus.m_pwrite) ? bus.m_prdata : '0;
            state           <= RESP;
          end else begin
            lat_cnt  <= lat_inc;
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
        {bus.m_pwrite, bus.m_paddr, bus.m_pwdata} <= head;
        bus.m_psel <= 1'b1;
        lat_cnt    <= LAT_WIDTH'(1);
        wait_cnt   <= '0;
        state      <= SETUP;
      end
    end
  end

  // A clear coinciding with a completion starts from the cleared values,
  // so the statistics then describe only that completion.
  always_comb begin
    cnt_nxt = stat_clear ? '0 : stat_count;
    err_nxt = stat_clear ? '0 : stat_errors;
    tmo_nxt = stat_clear ? '0 : stat_timeouts;
    min_nxt = stat_clear ? LAT_ONES : stat_lat_min;
    max_nxt = stat_clear ? '0 : stat_lat_max;
    if (done) begin
      cnt_nxt = sat_inc(cnt_nxt);
      if (bus.m_pready && bus.m_pslverr) err_nxt = sat_inc(err_nxt);
      if (!bus.m_pready) begin
        tmo_nxt = sat_inc(tmo_nxt);
      end else begin
        if (lat_cnt < min_nxt) min_nxt = lat_cnt;
        if (lat_cnt > max_nxt) max_nxt = lat_cnt;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      stat_count    <= '0;
      stat_errors   <= '0;
      stat_timeouts <= '0;
      stat_lat_min  <= LAT_ONES;
      stat_lat_max  <= '0;
    end else begin
      stat_count    <= cnt_nxt;
      stat_errors   <= err_nxt;
      stat_timeouts <= tmo_nxt;
      stat_lat_min  <= min_nxt;
      stat_lat_max  <= max_nxt;
    end
  end
endmodule

// File: tb/tb_apb_txn_sequencer.sv
// tb_apb_txn_sequencer
//   Drives commands into apb_txn_sequencer, emulates an APB completer that
//   follows a per-command plan (wait states, pslverr, read data), and checks
//   every response through a scoreboard fed by a specification-level model.
module tb_apb_txn_sequencer;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = 16;
  localparam int TMO   = 8;
  localparam int LMAX  = 65535;

  logic                   pclk = 1'b0;
  logic                   preset_n = 1'b0;
  logic                   stat_clear = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   busy;
  logic [LW-1:0]          stat_count, stat_errors, stat_timeouts, stat_lat_min, stat_lat_max;

  apb_txn_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAT_WIDTH(LW)) bus ();

  apb_txn_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .LAT_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n), .bus(bus),
    .fifo_level(fifo_level), .busy(busy), .stat_clear(stat_clear),
    .stat_count(stat_count), .stat_errors(stat_errors), .stat_timeouts(stat_timeouts),
    .stat_lat_min(stat_lat_min), .stat_lat_max(stat_lat_max)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic          slverr;
    logic [DW-1:0] rdata;
  } plan_t;

  typedef struct {
    logic          write;
    logic [DW-1:0] rdata;
    logic          err;
    logic          timeout;
    int            latency;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    setup_cyc[$];
  int    checks_total = 0;
  int    checks_passed = 0;
  int    cyc = 0;
  int    rdy_mode = 0;
  logic  rdy_fixed = 1'b1;
  int    m_cnt, m_err, m_to, m_min, m_max;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Response expected from the completer plan, straight from the transfer rules
  function automatic exp_t model(input plan_t p);
    exp_t e;
    e.write = p.write;
    if (p.waits < TMO) begin
      e.latency = p.waits + 2;
      e.err     = p.slverr;
      e.timeout = 1'b0;
      e.rdata   = p.write ? '0 : p.rdata;
    end else begin
      e.latency = TMO + 1;
      e.err     = 1'b0;
      e.timeout = 1'b1;
      e.rdata   = '0;
    end
    return e;
  endfunction

  function automatic int sat(input int v);
    return (v > LMAX) ? LMAX : v;
  endfunction

  task automatic reset_model_stats();
    m_cnt = 0; m_err = 0; m_to = 0; m_min = LMAX; m_max = 0;
  endtask

  task automatic apply_stimulus(input logic write, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int waits,
                                input logic slverr, input logic [DW-1:0] rdata);
    plan_t p;
    int guard;
    guard = 0;
    p = '{write: write, addr: addr, wdata: wdata, waits: waits, slverr: slverr, rdata: rdata};
    bus.cmd_write = write;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && guard < 2000) begin
      @(posedge pclk); #1;
      guard++;
    end
    if (!bus.cmd_ready) begin
      check_output("cmd_accept_timeout", guard, 0);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    plan_q.push_back(p);
    exp_q.push_back(model(p));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || bus.rsp_valid || exp_q.size() != 0) && guard < 3000) begin
      @(posedge pclk); #1;
      guard++;
    end
    if (guard >= 3000) check_output("idle_timeout", guard, 0);
  endtask

  task automatic check_stats(input string tag);
    check_output({tag, "_stat_count"},    stat_count,    m_cnt);
    check_output({tag, "_stat_errors"},   stat_errors,   m_err);
    check_output({tag, "_stat_timeouts"}, stat_timeouts, m_to);
    check_output({tag, "_stat_lat_min"},  stat_lat_min,  m_min);
    check_output({tag, "_stat_lat_max"},  stat_lat_max,  m_max);
  endtask

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  // rsp_ready driver: fixed level or random backpressure
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge pclk); #1;
      bus.rsp_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // APB completer following the plan queue; also checks issued address/data
  // and how long psel stays high for each transfer
  initial begin
    plan_t cur;
    exp_t  ce;
    int    acc_idx;
    int    psel_cycles;
    logic  have_cur;
    have_cur = 1'b0; acc_idx = 0; psel_cycles = 0;
    bus.m_pready = 1'b0; bus.m_pslverr = 1'b0; bus.m_prdata = '0;
    forever begin
      @(negedge pclk);
      if (!preset_n) begin
        have_cur = 1'b0; psel_cycles = 0;
        bus.m_pready = 1'b0; bus.m_pslverr = 1'b0;
      end else begin
        if (bus.m_psel) begin
          psel_cycles++;
        end else if (psel_cycles > 0) begin
          if (have_cur) begin
            ce = model(cur);
            check_output("psel_cycles", psel_cycles, ce.latency);
          end
          psel_cycles = 0;
        end
        if (bus.m_psel && !bus.m_penable) begin
          check_output("plan_available", plan_q.size() > 0, 1);
          if (plan_q.size() > 0) begin
            cur = plan_q.pop_front();
            have_cur = 1'b1;
            check_output("setup_pwrite", bus.m_pwrite, cur.write);
            check_output("setup_paddr",  bus.m_paddr,  cur.addr);
            if (cur.write) check_output("setup_pwdata", bus.m_pwdata, cur.wdata);
          end
          setup_cyc.push_back(cyc);
          acc_idx = 0;
          bus.m_pready = 1'b0;
        end else if (bus.m_psel && bus.m_penable && have_cur) begin
          if (acc_idx == cur.waits) begin
            bus.m_pready  = 1'b1;
            bus.m_prdata  = cur.rdata;
            bus.m_pslverr = cur.slverr;
          end else begin
            bus.m_pready  = 1'b0;
            bus.m_prdata  = $urandom;
            bus.m_pslverr = 1'($urandom_range(0, 1));
          end
          acc_idx++;
        end else begin
          bus.m_pready  = 1'b0;
          bus.m_pslverr = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted response
  initial forever begin
    exp_t e;
    @(negedge pclk);
    if (preset_n && bus.rsp_valid && bus.rsp_ready) begin
      check_output("rsp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("rsp_write",   bus.rsp_write,   e.write);
        check_output("rsp_rdata",   bus.rsp_rdata,   e.rdata);
        check_output("rsp_err",     bus.rsp_err,     e.err);
        check_output("rsp_timeout", bus.rsp_timeout, e.timeout);
        check_output("rsp_latency", bus.rsp_latency, e.latency);
        m_cnt = sat(m_cnt + 1);
        if (e.err) m_err = sat(m_err + 1);
        if (e.timeout) m_to = sat(m_to + 1);
        else begin
          if (e.latency < m_min) m_min = e.latency;
          if (e.latency > m_max) m_max = e.latency;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete, got time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    int r, w;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    reset_model_stats();

    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    check_output("rst_psel",        bus.m_psel,      0);
    check_output("rst_penable",     bus.m_penable,   0);
    check_output("rst_paddr",       bus.m_paddr,     0);
    check_output("rst_pwdata",      bus.m_pwdata,    0);
    check_output("rst_rsp_valid",   bus.rsp_valid,   0);
    check_output("rst_rsp_latency", bus.rsp_latency, 0);
    check_output("rst_cmd_ready",   bus.cmd_ready,   1);
    check_output("rst_busy",        busy,            0);
    check_output("rst_fifo_level",  fifo_level,      0);
    check_stats("rst");
    @(negedge pclk);
    preset_n = 1'b1;
    @(posedge pclk); #1;

    // Single zero-wait read
    apply_stimulus(1'b0, 32'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF);
    wait_idle();
    check_stats("read0");

    // Back-to-back writes with 0, 3, 1 wait states
    setup_cyc.delete();
    apply_stimulus(1'b1, 32'h20, 32'h1111, 0, 1'b0, $urandom);
    apply_stimulus(1'b1, 32'h24, 32'h2222, 3, 1'b0, $urandom);
    apply_stimulus(1'b1, 32'h28, 32'h3333, 1, 1'b0, $urandom);
    wait_idle();
    check_output("setup_count", setup_cyc.size(), 3);
    if (setup_cyc.size() == 3) begin
      check_output("setup_gap0", setup_cyc[1] - setup_cyc[0], 3);
      check_output("setup_gap1", setup_cyc[2] - setup_cyc[1], 6);
    end
    check_stats("writes");

    // Statistics clear, then a timeout
    stat_clear = 1'b1;
    @(posedge pclk); #1;
    stat_clear = 1'b0;
    reset_model_stats();
    check_stats("clear");
    apply_stimulus(1'b0, 32'h30, 32'h0, 100, 1'b0, 32'hCAFE);
    wait_idle();
    check_stats("timeout");

    // pready on the timeout cycle with pslverr
    apply_stimulus(1'b0, 32'h34, 32'h0, TMO - 1, 1'b1, 32'h12345678);
    wait_idle();
    check_stats("coincide");

    // FIFO fill under response backpressure
    rdy_fixed = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'b0, 32'h100 + 32'(i * 4), 32'h0, 0, 1'b0, 32'hA000 + 32'(i));
    repeat (3) @(posedge pclk);
    #1;
    check_output("full_cmd_ready",  bus.cmd_ready, 0);
    check_output("full_fifo_level", fifo_level,    DEPTH);
    check_output("full_rsp_valid",  bus.rsp_valid, 1);
    check_output("full_busy",       busy,          1);
    check_output("full_psel",       bus.m_psel,    0);
    rdy_fixed = 1'b1;
    apply_stimulus(1'b1, 32'h200, 32'h5555, 0, 1'b0, $urandom);
    wait_idle();
    check_stats("fifo");

    // Statistics clear coinciding with a latency-4 completion
    apply_stimulus(1'b1, 32'h50, 32'hAA, 2, 1'b0, $urandom);
    guard = 0;
    do begin
      @(negedge pclk); #1;
      guard++;
    end while (!(bus.m_psel && bus.m_penable && bus.m_pready) && guard < 100);
    if (guard >= 100) check_output("clear_wait_timeout", guard, 0);
    stat_clear = 1'b1;
    @(posedge pclk); #1;
    stat_clear = 1'b0;
    reset_model_stats();
    wait_idle();
    check_stats("clear_coincide");

    // Randomized traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       w = $urandom_range(0, 3);
      else if (r == 6) w = TMO - 1;
      else if (r == 7) w = TMO;
      else             w = $urandom_range(4, 12);
      apply_stimulus(1'($urandom_range(0, 1)), $urandom, $urandom, w,
                     1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge pclk);
      #1;
    end
    rdy_mode = 0;
    rdy_fixed = 1'b1;
    wait_idle();
    check_stats("random");

    // Reset during ACCESS with commands queued
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 32'h300 + 32'(i * 4), 32'h0, 50, 1'b0, $urandom);
    guard = 0;
    do begin
      @(negedge pclk); #1;
      guard++;
    end while (!(bus.m_psel && bus.m_penable) && guard < 100);
    if (guard >= 100) check_output("access_wait_timeout", guard, 0);
    check_output("pre_rst_fifo_level", fifo_level, 2);
    preset_n = 1'b0;
    #1;
    check_output("midrst_psel",       bus.m_psel,    0);
    check_output("midrst_penable",    bus.m_penable, 0);
    check_output("midrst_fifo_level", fifo_level,    0);
    check_output("midrst_busy",       busy,          0);
    check_output("midrst_cmd_ready",  bus.cmd_ready, 1);
    check_output("midrst_rsp_valid",  bus.rsp_valid, 0);
    plan_q.delete();
    exp_q.delete();
    reset_model_stats();
    check_stats("midrst");
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    @(posedge pclk); #1;
    apply_stimulus(1'b0, 32'h400, 32'h0, 1, 1'b0, 32'h0BADF00D);
    wait_idle();
    check_stats("post_rst");

    check_output("scoreboard_empty", exp_q.size(), 0);
    check_output("plan_empty", plan_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
